// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises a latched pattern MSB first, repeats it
// repeat_n+1 times with an optional idle gap between repetitions, and
// pulses done on the final transmitted bit. All outputs are registered.
module seq_pattern_tx #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap,
  output logic             ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;     // repetitions still to start after the current one
  logic [CNT_W-1:0] gap_q, gap_d;     // latched gap length
  logic [CNT_W-1:0] gcnt_q, gcnt_d;   // idle cycles left in GAP
  logic [IDX_W-1:0] idx_q, idx_d;     // index of the bit currently on bit_out
  logic             ready_q, ready_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] idx_dec_s;
  logic [CNT_W-1:0] rep_dec_s;
  logic [CNT_W-1:0] gcnt_dec_s;

  assign ready     = ready_q;
  assign bit_out   = bit_q;
  assign bit_valid = valid_q;
  assign done      = done_q;

  // Decrement helpers shared by the next-state logic.
  always_comb begin
    idx_dec_s  = idx_q - 1'b1;
    rep_dec_s  = rep_q - 1'b1;
    gcnt_dec_s = gcnt_q - 1'b1;
  end

  // Next-state and next-output logic; outputs default to the idle values.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    ready_d = 1'b1;
    bit_d   = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Accept: latch the request and present the MSB next cycle.
          pat_d   = pattern;
          rep_d   = repeat_n;
          gap_d   = gap;
          gcnt_d  = CNT_ZERO;
          idx_d   = MSB_IDX;
          state_d = SHIFT;
          ready_d = 1'b0;
          bit_d   = pattern[WIDTH-1];
          valid_d = 1'b1;
          done_d  = (MSB_IDX == IDX_ZERO) && (repeat_n == CNT_ZERO);
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q != IDX_ZERO) begin
          // Walk toward the LSB within the current repetition.
          idx_d   = idx_dec_s;
          ready_d = 1'b0;
          bit_d   = pat_q[idx_dec_s];
          valid_d = 1'b1;
          done_d  = (idx_dec_s == IDX_ZERO) && (rep_q == CNT_ZERO);
        end else if (rep_q == CNT_ZERO) begin
          // Final LSB is on the outputs now; go idle.
          state_d = IDLE;
        end else begin
          rep_d   = rep_dec_s;
          ready_d = 1'b0;
          if (gap_q == CNT_ZERO) begin
            // Back-to-back repetition: reload the index and send the MSB.
            idx_d   = MSB_IDX;
            bit_d   = pat_q[WIDTH-1];
            valid_d = 1'b1;
            done_d  = (MSB_IDX == IDX_ZERO) && (rep_q == CNT_ONE);
          end else begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gcnt_q == CNT_ONE) begin
          // Last idle cycle: next cycle restarts the pattern at the MSB.
          state_d = SHIFT;
          gcnt_d  = CNT_ZERO;
          idx_d   = MSB_IDX;
          ready_d = 1'b0;
          bit_d   = pat_q[WIDTH-1];
          valid_d = 1'b1;
          done_d  = (MSB_IDX == IDX_ZERO) && (rep_q == CNT_ZERO);
        end else begin
          gcnt_d  = gcnt_dec_s;
          ready_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= {WIDTH{1'b0}};
      rep_q   <= CNT_ZERO;
      gap_q   <= CNT_ZERO;
      gcnt_q  <= CNT_ZERO;
      idx_q   <= IDX_ZERO;
      ready_q <= 1'b1;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: directed scenarios plus randomized
// transfers, each compared cycle by cycle against a stream model built
// from the repeat/gap rules.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] pattern;
  logic [3:0] repeat_n;
  logic [3:0] gap;
  logic       ready;
  logic       bit_out;
  logic       bit_valid;
  logic       done;

  logic [3:0] obs;
  logic [3:0] exp_q[$];
  int tests_run;
  int tests_failed;

  assign obs = {ready, bit_valid, bit_out, done};

  seq_pattern_tx #(.WIDTH(6), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .repeat_n(repeat_n), .gap(gap),
    .ready(ready), .bit_out(bit_out), .bit_valid(bit_valid), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {ready,bit_valid,bit_out,done} for cycles 1..N after an accept,
  // followed by one idle entry for the cycle after the transfer.
  function automatic void build_exp(input logic [5:0] p, input int rep, input int g);
    exp_q.delete();
    for (int r = 0; r <= rep; r++) begin
      for (int i = 5; i >= 0; i--)
        exp_q.push_back({1'b0, 1'b1, p[i], (r == rep && i == 0)});
      if (r < rep)
        for (int k = 0; k < g; k++) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b1000);
  endfunction

  task automatic launch(input logic [5:0] p, input logic [3:0] r, input logic [3:0] g);
    @(negedge clk);
    start = 1'b1; pattern = p; repeat_n = r; gap = g;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 6'd0; repeat_n = 4'd0; gap = 4'd0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (obs !== 4'b1000) begin tests_failed++; $display("FAIL reset_state: got %b want 1000", obs); end
    start = 1'b1; abort = 1'b1; pattern = 6'b111111;
    @(negedge clk);
    tests_run++;
    if (obs !== 4'b1000) begin tests_failed++; $display("FAIL reset_priority: got %b want 1000", obs); end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs !== 4'b1000) begin tests_failed++; $display("FAIL reset_release: got %b want 1000", obs); end
  endtask

  task automatic test_single();
    int done_cyc = 0;
    build_exp(6'b110110, 0, 0);
    launch(6'b110110, 4'd0, 4'd0);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL single c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (done === 1'b1) done_cyc = c;
    end
    tests_run++;
    if (done_cyc != 6) begin tests_failed++; $display("FAIL single_done_cycle: got %0d want 6", done_cyc); end
  endtask

  task automatic test_gapless_repeat();
    logic [5:0] sh = 6'd0;
    int nvalid = 0;
    int flags[$];
    build_exp(6'b110110, 1, 0);
    launch(6'b110110, 4'd1, 4'd0);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL gapless c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (bit_valid === 1'b1) begin
        sh = {sh[4:0], bit_out};
        nvalid++;
        if (nvalid >= 6 && sh == 6'b110110) flags.push_back(c);
      end
    end
    tests_run++;
    if (flags.size() != 3 || flags[0] != 6 || flags[1] != 9 || flags[2] != 12) begin
      tests_failed++; $display("FAIL detector_flags: got %p want 6,9,12", flags);
    end
  endtask

  task automatic test_gap();
    int done_cyc = 0;
    build_exp(6'b101100, 1, 3);
    launch(6'b101100, 4'd1, 4'd3);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL gap c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (done === 1'b1) done_cyc = c;
    end
    tests_run++;
    if (done_cyc != 15) begin tests_failed++; $display("FAIL gap_done_cycle: got %0d want 15", done_cyc); end
  endtask

  task automatic test_ignored_start();
    build_exp(6'b110010, 1, 1);
    launch(6'b110010, 4'd1, 4'd1);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL ignored_start c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (c == 3) begin start = 1'b1; pattern = 6'b001011; repeat_n = 4'd3; gap = 4'd2; end
      else start = 1'b0;
    end
  endtask

  task automatic test_abort_reset();
    build_exp(6'b101101, 1, 2);
    launch(6'b101101, 4'd1, 4'd2);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL abort_pre c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (c == 4) abort = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); abort = 1'b0;
      tests_run++;
      if (obs !== 4'b1000) begin tests_failed++; $display("FAIL abort_idle k%0d: got %b want 1000", k, obs); end
    end
    build_exp(6'b011010, 2, 1);
    launch(6'b011010, 4'd2, 4'd1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL rst_pre c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (c == 3) rst = 1'b1;
    end
    @(negedge clk); rst = 1'b0;
    tests_run++;
    if (obs !== 4'b1000) begin tests_failed++; $display("FAIL rst_mid: got %b want 1000", obs); end
    build_exp(6'b100111, 1, 1);
    launch(6'b100111, 4'd1, 4'd1);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL post_rst c%0d: got %b want %b", c, obs, exp_q[c-1]); end
    end
  endtask

  task automatic test_abort_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); abort = 1'b1;
      tests_run++;
      if (obs !== 4'b1000) begin tests_failed++; $display("FAIL abort_in_idle k%0d: got %b want 1000", k, obs); end
    end
    build_exp(6'b010011, 0, 1);
    launch(6'b010011, 4'd0, 4'd1);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk); start = 1'b0; abort = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL start_wins c%0d: got %b want %b", c, obs, exp_q[c-1]); end
    end
  endtask

  task automatic test_abort_last();
    build_exp(6'b111001, 0, 0);
    launch(6'b111001, 4'd0, 4'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL abort_last c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (c == 6) abort = 1'b1;
    end
    @(negedge clk); abort = 1'b0;
    tests_run++;
    if (obs !== 4'b1000) begin tests_failed++; $display("FAIL abort_last_idle: got %b want 1000", obs); end
  endtask

  task automatic test_max_repeat();
    int done_cnt = 0;
    int done_cyc = 0;
    int nvalid = 0;
    build_exp(6'b110110, 15, 0);
    launch(6'b110110, 4'hF, 4'd0);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk); start = 1'b0;
      tests_run++;
      if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL max_repeat c%0d: got %b want %b", c, obs, exp_q[c-1]); end
      if (done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (bit_valid === 1'b1) nvalid++;
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 96 || nvalid != 96) begin
      tests_failed++;
      $display("FAIL max_repeat_totals: got done_cnt=%0d done_cyc=%0d valid=%0d want 1/96/96", done_cnt, done_cyc, nvalid);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [5:0] p;
      int r, g, len, ab, last;
      p = 6'($urandom);
      r = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      g = int'($urandom_range(0, 3));
      build_exp(p, r, g);
      len = exp_q.size() - 1;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
      last = (ab != 0) ? ab : len;
      launch(p, 4'(r), 4'(g));
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        tests_run++;
        if (obs !== exp_q[c-1]) begin tests_failed++; $display("FAIL random it%0d c%0d: got %b want %b", it, c, obs, exp_q[c-1]); end
        start = 1'($urandom_range(0, 1));
        pattern = 6'($urandom); repeat_n = 4'($urandom); gap = 4'($urandom);
        abort = (c == ab);
      end
      @(negedge clk); start = 1'b0; abort = 1'b0;
      tests_run++;
      if (obs !== 4'b1000) begin tests_failed++; $display("FAIL random_end it%0d: got %b want 1000", it, obs); end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_gapless_repeat();
    test_gap();
    test_ignored_start();
    test_abort_reset();
    test_abort_idle();
    test_abort_last();
    test_max_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
